pkt_tx_scheduler: RTL

Packet transmit scheduler for the GPIO UART link. Two requesters (motion-state echo and LiDAR report paths) each offer a 24-bit payload, {motion_state, lidar_x, lidar_y}. The block arbitrates between them round-robin, frames the winner as header, payload and optional checksum bytes, and sequences the bytes into a shared byte-level UART transmitter over a start/busy handshake. It sits between the packet producers and the single TX serializer driving the outgoing GPIO pin.

---
 rtl/pkt_tx_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pkt_tx_scheduler.sv
// Round-robin packet transmit scheduler: frames a 24-bit payload and feeds it byte-wise to a UART serializer.
// Optional XOR checksum byte enabled by defining PKT_SCHED_CHECKSUM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate between requesters, capture winner's payload
// SEND      | present frame[byte_idx], strobe tx_start once serializer idle
// WAIT_ACK  | wait for serializer to assert tx_busy
// WAIT_DONE | wait for tx_busy to drop, then next byte or end of frame
// GAP       | inter-frame idle time, down-counter to terminal count 0
module pkt_tx_scheduler #(
   parameter logic [7:0] HEADER     = 8'hAA,
   parameter int         GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [23:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [23:0] req1_data,
   output logic        req1_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        pkt_done
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP} state_t;

`ifdef PKT_SCHED_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]   GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t        state, state_nxt;
   logic [23:0]   payload, payload_nxt;
   logic [1:0]    grant_nxt;
   logic [2:0]    byte_idx, byte_idx_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic          last_ptr, last_ptr_nxt;
   logic          sel0, sel1;
   logic [7:0]    frame_byte;

   // last_ptr = 1 means req1 was served last, so req0 wins a tie
   assign sel0 = req0_valid & (~req1_valid | last_ptr);
   assign sel1 = req1_valid & (~req0_valid | ~last_ptr);

   assign req0_ready = rst_n & (state == IDLE) & sel0;
   assign req1_ready = rst_n & (state == IDLE) & sel1;
   assign busy       = (state != IDLE);

   always_comb begin
      frame_byte = 8'h00;
      case (byte_idx)
         3'd0:    frame_byte = HEADER;
         3'd1:    frame_byte = payload[23:16];
         3'd2:    frame_byte = payload[15:8];
         3'd3:    frame_byte = payload[7:0];
`ifdef PKT_SCHED_CHECKSUM_EN
         3'd4:    frame_byte = payload[23:16] ^ payload[15:8] ^ payload[7:0];
`endif
         default: frame_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         payload  <= '0;
         grant    <= 2'b00;
         byte_idx <= '0;
         gap_cnt  <= '0;
         last_ptr <= 1'b1;
      end else begin
         state    <= state_nxt;
         payload  <= payload_nxt;
         grant    <= grant_nxt;
         byte_idx <= byte_idx_nxt;
         gap_cnt  <= gap_cnt_nxt;
         last_ptr <= last_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      payload_nxt  = payload;
      grant_nxt    = grant;
      byte_idx_nxt = byte_idx;
      gap_cnt_nxt  = gap_cnt;
      last_ptr_nxt = last_ptr;
      tx_start     = 1'b0;
      tx_byte      = 8'h00;
      pkt_done     = 1'b0;

      case (state)
         IDLE: begin
            if (sel0) begin
               payload_nxt  = req0_data;
               grant_nxt    = 2'b01;
               last_ptr_nxt = 1'b0;
               byte_idx_nxt = '0;
               state_nxt    = SEND;
            end else if (sel1) begin
               payload_nxt  = req1_data;
               grant_nxt    = 2'b10;
               last_ptr_nxt = 1'b1;
               byte_idx_nxt = '0;
               state_nxt    = SEND;
            end
         end

         SEND: begin
            tx_byte = frame_byte;
            if (!tx_busy) begin
               tx_start  = 1'b1;
               state_nxt = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            tx_byte = frame_byte;
            if (tx_busy) state_nxt = WAIT_DONE;
         end

         WAIT_DONE: begin
            tx_byte = frame_byte;
            if (!tx_busy) begin
               if (byte_idx == LAST_IDX) begin
                  pkt_done     = 1'b1;
                  grant_nxt    = 2'b00;
                  byte_idx_nxt = '0;
                  if (GAP_CYCLES == 0) begin
                     state_nxt = IDLE;
                  end else begin
                     gap_cnt_nxt = GAP_LOAD;
                     state_nxt   = GAP;
                  end
               end else begin
                  byte_idx_nxt = byte_idx + 3'd1;
                  state_nxt    = SEND;
               end
            end
         end

         GAP: begin
            if (gap_cnt == '0) state_nxt = IDLE;
            else               gap_cnt_nxt = gap_cnt - 1'b1;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
